multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core datapath: fetch, decode, execute, memory, writeback.
- Latches the instruction word and drives the shared ALU's ALUop/funct3/funct7 and operand selects.
- Owns instruction and data memory handshakes, PC/register-file write enables and trap detection.
- Sits between the memories and the datapath (ALU, register file, PC register, branch/jump target adder).

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/mem/writeback control,
// memory handshakes, PC/RF write strobes and sticky trap reporting.
//
//  state   | meaning
//  FETCH   | imem_req high, wait for imem_valid, latch ir
//  DECODE  | classify opcode, trap on illegal
//  EXECUTE | drive ALU controls; branches resolve and retire here
//  MEM     | dmem_req high, wait for dmem_ready; stores retire here
//  WB      | register-file write, PC update, retire
//  TRAP    | all strobes low, stays until reset
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        branch_taken,
    output logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic [2:0]  alu_funct3,
    output logic [6:0]  alu_funct7,
    output logic        alu_src1_pc,
    output logic        alu_src2_imm,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        retired,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_TRAP    = 3'd7
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t        cur;
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;

    logic          is_ld, is_st, is_br, is_jal, is_jalr, legal;
    logic [3:0]    ex_alu_op;
    logic          ex_src1_pc, ex_src2_imm;

    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    always_comb begin
        is_ld       = 1'b0;
        is_st       = 1'b0;
        is_br       = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        legal       = 1'b1;
        ex_alu_op   = 4'b0000;
        ex_src1_pc  = 1'b0;
        ex_src2_imm = 1'b0;
        case (ir[6:0])
            OP_R:    ex_alu_op = 4'b0000;
            OP_I:    begin ex_alu_op = 4'b0001; ex_src2_imm = 1'b1; end
            OP_LD:   begin ex_alu_op = 4'b0010; ex_src2_imm = 1'b1; is_ld = 1'b1; end
            OP_ST:   begin ex_alu_op = 4'b0010; ex_src2_imm = 1'b1; is_st = 1'b1; end
            OP_BR:   begin ex_alu_op = 4'b0011; is_br = 1'b1; end
            OP_JAL:  begin ex_alu_op = 4'b0100; ex_src1_pc = 1'b1; is_jal = 1'b1; end
            OP_JALR: begin ex_alu_op = 4'b0100; ex_src1_pc = 1'b1; is_jalr = 1'b1; end
            OP_LUI:  begin ex_alu_op = 4'b0101; ex_src2_imm = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    // The wait counter restarts on every state entry; it only advances while
    // a memory request is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur        <= S_FETCH;
            ir         <= 32'h0000_0013;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            wait_cnt   <= '0;
        end else begin
            wait_cnt <= '0;
            case (cur)
                S_FETCH: begin
                    if (imem_valid) begin
                        ir  <= imem_rdata;
                        cur <= S_DECODE;
                    end else if (timeout_hit) begin
                        cur        <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd2;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        cur <= S_EXECUTE;
                    end else begin
                        cur        <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd1;
                    end
                end
                S_EXECUTE: begin
                    if (is_br)               cur <= S_FETCH;
                    else if (is_ld || is_st) cur <= S_MEM;
                    else                     cur <= S_WB;
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        cur <= is_st ? S_FETCH : S_WB;
                    end else if (timeout_hit) begin
                        cur        <= S_TRAP;
                        trap       <= 1'b1;
                        trap_cause <= 2'd3;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_WB:    cur <= S_FETCH;
                S_TRAP:  cur <= S_TRAP;
                default: cur <= S_FETCH;
            endcase
        end
    end

    assign state      = cur;
    assign alu_funct3 = ir[14:12];
    assign alu_funct7 = ir[31:25];

    // ALU controls stay at their EXECUTE values through MEM and WB so the
    // address / result seen by the datapath does not move.
    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        alu_op       = 4'b0000;
        alu_src1_pc  = 1'b0;
        alu_src2_imm = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        rf_we        = 1'b0;
        wb_sel       = 2'd0;
        retired      = 1'b0;
        case (cur)
            S_FETCH: imem_req = 1'b1;
            S_EXECUTE: begin
                alu_op       = ex_alu_op;
                alu_src1_pc  = ex_src1_pc;
                alu_src2_imm = ex_src2_imm;
                if (is_br) begin
                    pc_we   = 1'b1;
                    pc_sel  = branch_taken ? 2'd1 : 2'd0;
                    retired = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req     = 1'b1;
                dmem_we      = is_st;
                alu_op       = ex_alu_op;
                alu_src1_pc  = ex_src1_pc;
                alu_src2_imm = ex_src2_imm;
                if (dmem_ready && is_st) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WB: begin
                alu_op       = ex_alu_op;
                alu_src1_pc  = ex_src1_pc;
                alu_src2_imm = ex_src2_imm;
                rf_we        = (ir[11:7] != 5'd0);
                wb_sel       = is_ld ? 2'd1 : 2'd0;
                pc_we        = 1'b1;
                pc_sel       = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
                retired      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, reset/trap sequences and
// random instructions checked against an instruction-level latency model.
module tb_multicycle_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_valid, dmem_req, dmem_we, dmem_ready, branch_taken;
    logic [31:0] imem_rdata, ir;
    logic [3:0]  alu_op;
    logic [2:0]  alu_funct3, state;
    logic [6:0]  alu_funct7;
    logic        alu_src1_pc, alu_src2_imm, pc_we, rf_we, retired, trap;
    logic [1:0]  pc_sel, wb_sel, trap_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken), .ir(ir),
        .alu_op(alu_op), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_src1_pc(alu_src1_pc), .alu_src2_imm(alu_src2_imm),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .retired(retired), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    typedef struct {
        int lat; int alu; int s1; int s2; int pcsel; int rf; int wb;
        int dreq; int dwe; int cause; int ret; int pcwe; int trapv;
        int exec_seen; int f3; int f7; int irv;
    } obs_t;

    typedef struct {
        logic [31:0] instr; int di; int dm; logic tk; obs_t exp;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t mkexp(int lat, int alu, int s1, int s2, int pcsel,
                                   int rf, int wb, int dreq, int dwe, int cause);
        obs_t e = '{default: 0};
        e.lat = lat; e.alu = alu; e.s1 = s1; e.s2 = s2; e.pcsel = pcsel;
        e.rf = rf; e.wb = wb; e.dreq = dreq; e.dwe = dwe; e.cause = cause;
        e.ret = (cause == 0) ? 1 : 0;
        e.pcwe = e.ret;
        e.trapv = (cause != 0) ? 1 : 0;
        return e;
    endfunction

    // Instruction-level model: cycle counts from fetch waits, class and data waits.
    function automatic obs_t model(logic [31:0] instr, int di, int dm, logic tk);
        logic [6:0] opc = instr[6:0];
        int rdnz = (instr[11:7] != 5'd0) ? 1 : 0;
        int f, m;
        if (di >= TO) return mkexp(TO + 1, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        f = di + 1;
        case (opc)
            7'b0110011: return mkexp(f + 3, 0, 0, 0, 0, rdnz, 0, 0, 0, 0);
            7'b0010011: return mkexp(f + 3, 1, 0, 1, 0, rdnz, 0, 0, 0, 0);
            7'b0110111: return mkexp(f + 3, 5, 0, 1, 0, rdnz, 0, 0, 0, 0);
            7'b1101111: return mkexp(f + 3, 4, 1, 0, 1, rdnz, 0, 0, 0, 0);
            7'b1100111: return mkexp(f + 3, 4, 1, 0, 2, rdnz, 0, 0, 0, 0);
            7'b1100011: return mkexp(f + 2, 3, 0, 0, tk ? 1 : 0, 0, 0, 0, 0, 0);
            7'b0000011, 7'b0100011: begin
                int st = (opc == 7'b0100011) ? 1 : 0;
                if (dm >= TO) return mkexp(f + 3 + TO, 2, 0, 1, 0, 0, 0, TO, st, 3);
                m = dm + 1;
                if (st == 1) return mkexp(f + 2 + m, 2, 0, 1, 0, 0, 0, m, 1, 0);
                return mkexp(f + 3 + m, 2, 0, 1, 0, rdnz, 1, m, 0, 0);
            end
            default: return mkexp(f + 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        endcase
    endfunction

    // Starts just after a rising edge with the DUT in FETCH; acts as both memories.
    task automatic run_instr(input logic [31:0] instr, input int di, input int dm,
                             input logic tk, output obs_t o);
        int icnt = 0, dcnt = 0;
        bit done = 0;
        o = '{default: 0};
        for (int c = 1; c <= 64 && !done; c++) begin
            imem_rdata   = instr;
            branch_taken = tk;
            imem_valid   = imem_req && (icnt >= di);
            dmem_ready   = dmem_req && (dcnt >= dm);
            if (imem_req) icnt++;
            if (dmem_req) dcnt++;
            @(negedge clk);
            if (dmem_req) begin o.dreq++; o.dwe = int'(dmem_we); end
            if (state == 3'd2) begin
                o.exec_seen = 1;
                o.alu = int'(alu_op); o.s1 = int'(alu_src1_pc); o.s2 = int'(alu_src2_imm);
                o.f3 = int'(alu_funct3); o.f7 = int'(alu_funct7); o.irv = int'(ir);
            end
            if (state == 3'd4) o.wb = int'(wb_sel);
            if (rf_we) o.rf++;
            if (pc_we) begin o.pcwe++; o.pcsel = int'(pc_sel); end
            if (retired) begin o.ret++; o.lat = c; done = 1; end
            if (state == 3'd7) begin
                o.trapv = int'(trap); o.cause = int'(trap_cause); o.lat = c; done = 1;
            end
            @(posedge clk); #1;
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        if (!done) chk("run_bound", 0, 1);
    endtask

    task automatic compare(input string tag, input logic [31:0] instr, input obs_t o,
                           input obs_t e);
        chk({tag, ".latency"}, o.lat, e.lat);
        chk({tag, ".retired"}, o.ret, e.ret);
        chk({tag, ".pc_we"}, o.pcwe, e.pcwe);
        chk({tag, ".pc_sel"}, o.pcsel, e.pcsel);
        chk({tag, ".rf_we"}, o.rf, e.rf);
        chk({tag, ".wb_sel"}, o.wb, e.wb);
        chk({tag, ".dmem_cycles"}, o.dreq, e.dreq);
        chk({tag, ".dmem_we"}, o.dwe, e.dwe);
        chk({tag, ".trap"}, o.trapv, e.trapv);
        chk({tag, ".cause"}, o.cause, e.cause);
        chk({tag, ".alu_op"}, o.alu, e.alu);
        chk({tag, ".src1_pc"}, o.s1, e.s1);
        chk({tag, ".src2_imm"}, o.s2, e.s2);
        if (e.cause == 0 || e.cause == 3) begin
            chk({tag, ".ir"}, o.irv, int'(instr));
            chk({tag, ".funct3"}, o.f3, int'(instr[14:12]));
            chk({tag, ".funct7"}, o.f7, int'(instr[31:25]));
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    vec_t vecs[12];
    obs_t o, e;

    initial begin
        rst_n = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0;
        branch_taken = 1'b0; imem_rdata = '0;

        vecs[0]  = '{32'h002081B3, 0, 0, 1'b0, mkexp(4, 0, 0, 0, 0, 1, 0, 0, 0, 0)};
        vecs[1]  = '{32'h00208463, 0, 0, 1'b1, mkexp(3, 3, 0, 0, 1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{32'h00208463, 1, 0, 1'b0, mkexp(4, 3, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{32'h0000A283, 0, 3, 1'b0, mkexp(8, 2, 0, 1, 0, 1, 1, 4, 0, 0)};
        vecs[4]  = '{32'h00100013, 0, 0, 1'b0, mkexp(4, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[5]  = '{32'h0020A023, 0, 0, 1'b0, mkexp(4, 2, 0, 1, 0, 0, 0, 1, 1, 0)};
        vecs[6]  = '{32'h000000EF, 2, 0, 1'b0, mkexp(6, 4, 1, 0, 1, 1, 0, 0, 0, 0)};
        vecs[7]  = '{32'h000100E7, 0, 0, 1'b0, mkexp(4, 4, 1, 0, 2, 1, 0, 0, 0, 0)};
        vecs[8]  = '{32'h123452B7, 0, 0, 1'b0, mkexp(4, 5, 0, 1, 0, 1, 0, 0, 0, 0)};
        vecs[9]  = '{32'h0000007F, 0, 0, 1'b0, mkexp(3, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
        vecs[10] = '{32'h002081B3, 9, 0, 1'b0, mkexp(5, 0, 0, 0, 0, 0, 0, 0, 0, 2)};
        vecs[11] = '{32'h0000A283, 0, 9, 1'b0, mkexp(8, 2, 0, 1, 0, 0, 0, 4, 0, 3)};

        // reset values while rst_n is held low
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst.state", state, 0);
        chk("rst.ir", ir, 32'h00000013);
        chk("rst.trap", trap, 0);
        chk("rst.cause", trap_cause, 0);
        chk("rst.imem_req", imem_req, 1);
        chk("rst.strobes", {dmem_req, pc_we, rf_we, retired}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_instr(vecs[i].instr, vecs[i].di, vecs[i].dm, vecs[i].tk, o);
            compare($sformatf("vec%0d", i), vecs[i].instr, o, vecs[i].exp);
            if (vecs[i].exp.cause != 0) reset_pulse();
        end

        // illegal opcode: trap is sticky and fetch stays idle until reset
        run_instr(32'h0000007F, 0, 0, 1'b0, o);
        imem_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("trap.state", state, 7);
        chk("trap.flag", trap, 1);
        chk("trap.cause", trap_cause, 1);
        chk("trap.imem_req", imem_req, 0);
        chk("trap.retired", retired, 0);
        imem_valid = 1'b0;
        @(posedge clk); #1;
        reset_pulse();
        @(negedge clk);
        chk("trap_clr.state", state, 0);
        chk("trap_clr.flag", trap, 0);
        chk("trap_clr.cause", trap_cause, 0);

        // reset while a load waits in MEM drops dmem_req on the next edge
        imem_rdata = 32'h0000A283; imem_valid = 1'b1;
        @(posedge clk); #1; imem_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst.mem_state", state, 3);
        chk("midrst.dmem_req", dmem_req, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst.req_before_edge", dmem_req, 1);
        @(negedge clk);
        chk("midrst.state", state, 0);
        chk("midrst.dmem_req", dmem_req, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] r, instr;
            logic [6:0] opc;
            logic [6:0] ops [8];
            int di, dm;
            logic tk;
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
            r = $urandom;
            opc = ($urandom_range(0, 9) == 0) ? r[6:0] : ops[$urandom_range(0, 7)];
            instr = {r[31:7], opc};
            di = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            dm = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 2);
            tk = 1'($urandom_range(0, 1));
            e = model(instr, di, dm, tk);
            run_instr(instr, di, dm, tk, o);
            compare($sformatf("rnd%0d", n), instr, o, e);
            if (e.cause != 0 || o.trapv != 0) reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
